seven_seg_scan_controller: RTL

Time-multiplexed scan controller that shares one `seven_seg_driver_decimal` decoder among DIGITS common-anode digits. It holds a frame-synchronous shadow copy of the displayed BCD digits and steps a digit index through a GAP (all anodes off) / DRIVE (one anode on) cycle. It presents the selected digit's 4-bit code to the decoder's `number` input. It sits between the value-producing logic and the decoder/anode pins, and updates display content only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/seven_seg_scan_controller.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_controller.sv
// Time-multiplexed scan controller feeding one shared BCD decoder across DIGITS common-anode digits.
// Optional leading-zero blanking: define SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scan_controller #(
  parameter int DIGITS = 4,
  parameter int DWELL  = 1000,
  parameter int GAP    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic                  load,
  output logic                  pending,
  output logic [3:0]            number_out,
  output logic [DIGITS-1:0]     anode_n,
  output logic                  frame_done
);

  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CMAX = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW   = $clog2(CMAX);

  typedef enum logic {S_GAP, S_DRIVE} state_t;

  state_t                state, state_next;
  logic [CW-1:0]         cnt, cnt_next;
  logic [IW-1:0]         idx, idx_next;

  logic [4*DIGITS-1:0]   active, active_next;
  logic [4*DIGITS-1:0]   staged, staged_next;
  logic                  pending_next;
  logic [DIGITS-1:0]     anode_next;
  logic [DIGITS-1:0]     blank;
  logic [3:0]            number_next;
  logic                  frame_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_GAP;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    idx_next   = idx;
    case (state)
      S_GAP: begin
        if (cnt == CW'(GAP - 1)) begin
          state_next = S_DRIVE;
          cnt_next   = '0;
        end
      end
      S_DRIVE: begin
        if (cnt == CW'(DWELL - 1)) begin
          state_next = S_GAP;
          cnt_next   = '0;
          idx_next   = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end
      end
      default: begin
        state_next = S_GAP;
        cnt_next   = '0;
      end
    endcase
  end

  // The registered frame_done marks the frame boundary; a load there bypasses staging.
  always_comb begin
    active_next  = active;
    staged_next  = staged;
    pending_next = pending;
    if (frame_done) begin
      if (load)
        active_next = digits_in;
      else if (pending)
        active_next = staged;
      pending_next = 1'b0;
    end else if (load) begin
      staged_next  = digits_in;
      pending_next = 1'b1;
    end
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic zero_run;
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run && (active[4*k +: 4] == 4'd0);
      blank[k] = zero_run;
    end
  end
`else
  always_comb begin
    blank = '0;
  end
`endif

  // Outputs are computed from the next state so they can be registered without extra latency.
  always_comb begin
    anode_next  = '1;
    number_next = number_out;
    frame_next  = (state_next == S_DRIVE) && (idx_next == IW'(DIGITS - 1)) &&
                  (cnt_next == CW'(DWELL - 1));
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_next == IW'(k)) begin
        if (state_next == S_DRIVE && !blank[k])
          anode_next[k] = 1'b0;
        if (state_next == S_GAP && cnt_next == '0)
          number_next = active_next[4*k +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active     <= '0;
      staged     <= '0;
      pending    <= 1'b0;
      anode_n    <= '1;
      number_out <= 4'd0;
      frame_done <= 1'b0;
    end else begin
      active     <= active_next;
      staged     <= staged_next;
      pending    <= pending_next;
      anode_n    <= anode_next;
      number_out <= number_next;
      frame_done <= frame_next;
    end
  end

endmodule
